// File: rtl/sample_timer_ctrl.sv
// Packet bit-timing controller: half-bit alignment, N data bits of P cycles each, then a
// P-cycle stop period. Emits a per-bit shift strobe and an end-of-packet pulse.
module sample_timer_ctrl #(
  parameter int unsigned NUM_CNT_BITS = 8,
  parameter int unsigned NUM_IDX_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_CNT_BITS-1:0] bit_period,
  input  logic [NUM_IDX_BITS-1:0] num_bits,
  output logic                    busy,
  output logic                    shift_strobe,
  output logic                    packet_done,
  output logic [NUM_IDX_BITS-1:0] bit_index
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HALF = 2'd1,
    BITS = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);
  localparam logic [NUM_CNT_BITS-1:0] CNT_TWO = NUM_CNT_BITS'(2);
  localparam logic [NUM_IDX_BITS-1:0] IDX_ONE = NUM_IDX_BITS'(1);

  state_e                  state_q, state_d;
  logic [NUM_CNT_BITS-1:0] cnt_q, cnt_d;
  logic [NUM_CNT_BITS-1:0] per_q, per_d;
  logic [NUM_IDX_BITS-1:0] nbits_q, nbits_d;
  logic [NUM_IDX_BITS-1:0] idx_q, idx_d;

  logic [NUM_CNT_BITS-1:0] limit;
  logic [NUM_CNT_BITS-1:0] cnt_inc;
  logic                    last;

  // The counter runs 1..limit; reaching the limit marks the final cycle of the phase.
  always_comb begin
    limit   = (state_q == HALF) ? (per_q >> 1) : per_q;
    cnt_inc = cnt_q + CNT_ONE;
    last    = (cnt_inc == limit);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    nbits_d = nbits_q;
    idx_d   = idx_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (start && !abort) begin
          per_d   = (bit_period < CNT_TWO) ? CNT_TWO : bit_period;
          nbits_d = (num_bits == '0) ? IDX_ONE : num_bits;
          state_d = HALF;
        end
      end
      HALF: begin
        if (last) begin
          cnt_d   = '0;
          state_d = BITS;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      BITS: begin
        if (last) begin
          cnt_d = '0;
          if (idx_q == nbits_q - IDX_ONE) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STOP: begin
        if (last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      nbits_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      nbits_q <= nbits_d;
      idx_q   <= idx_d;
    end
  end

  // abort is the only input allowed to reach the outputs combinationally.
  always_comb begin
    busy         = (state_q != IDLE);
    shift_strobe = (state_q == BITS) && last && !abort;
    packet_done  = (state_q == STOP) && last && !abort;
    bit_index    = idx_q;
  end

endmodule

// File: tb/tb_sample_timer_ctrl.sv
// Self-checking bench for sample_timer_ctrl: directed scenarios plus random traffic,
// compared against an arithmetic per-cycle model of the packet timeline.
module tb_sample_timer_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic       abort;
  logic [7:0] bit_period;
  logic [3:0] num_bits;
  logic       busy;
  logic       shift_strobe;
  logic       packet_done;
  logic [3:0] bit_index;

  sample_timer_ctrl #(
    .NUM_CNT_BITS(8),
    .NUM_IDX_BITS(4)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .abort       (abort),
    .bit_period  (bit_period),
    .num_bits    (num_bits),
    .busy        (busy),
    .shift_strobe(shift_strobe),
    .packet_done (packet_done),
    .bit_index   (bit_index)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: position k within the accepted packet, plus the clamped captured values.
  bit m_act = 1'b0;
  int m_k, m_p, m_n, m_h;

  int cyc = 0;
  int q_str[$];
  int last_done = -1;
  int base;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic exp_out(input bit a, output bit e_busy, output bit e_str,
                         output bit e_done, output int e_idx);
    int len;
    bit in_bits;
    e_busy = 1'b0; e_str = 1'b0; e_done = 1'b0; e_idx = 0;
    if (m_act) begin
      len     = m_h + m_p * m_n + m_p;
      in_bits = (m_k >= m_h) && (m_k < m_h + m_p * m_n);
      e_busy  = 1'b1;
      e_idx   = in_bits ? (m_k - m_h) / m_p : 0;
      e_str   = in_bits && ((m_k - m_h) % m_p == m_p - 1) && !a;
      e_done  = (m_k == len - 1) && !a;
    end
  endtask

  task automatic model_edge(input bit s, input bit a, input int p, input int n);
    if (m_act) begin
      if (a) m_act = 1'b0;
      else begin
        m_k++;
        if (m_k >= m_h + m_p * m_n + m_p) m_act = 1'b0;
      end
    end else if (s && !a) begin
      m_act = 1'b1;
      m_k   = 0;
      m_p   = (p < 2) ? 2 : p;
      m_n   = (n == 0) ? 1 : n;
      m_h   = m_p / 2;
    end
  endtask

  // One clock cycle: drive just after the rising edge, check at the falling edge.
  task automatic tick(input bit s, input bit a, input int p, input int n);
    bit e_busy, e_str, e_done;
    int e_idx;
    start = s; abort = a; bit_period = 8'(p); num_bits = 4'(n);
    @(negedge clk);
    exp_out(a, e_busy, e_str, e_done, e_idx);
    cmp("busy", busy, e_busy);
    cmp("shift_strobe", shift_strobe, e_str);
    cmp("packet_done", packet_done, e_done);
    cmp("bit_index", bit_index, e_idx);
    cmp("strobe_done_exclusive", shift_strobe & packet_done, 0);
    if (shift_strobe === 1'b1) q_str.push_back(cyc);
    if (packet_done === 1'b1) last_done = cyc;
    @(posedge clk);
    model_edge(s, a, p, n);
    cyc++;
    #1;
  endtask

  task automatic cmp_all_zero(input string tag);
    cmp({tag, ".busy"}, busy, 0);
    cmp({tag, ".shift_strobe"}, shift_strobe, 0);
    cmp({tag, ".packet_done"}, packet_done, 0);
    cmp({tag, ".bit_index"}, bit_index, 0);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; abort = 1'b0; bit_period = '0; num_bits = '0;
    #1;
    cmp_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    cmp_all_zero("reset_held");
    n_rst = 1'b1;

    // Nominal P=4 N=3 packet
    tick(1, 0, 4, 3);
    base = cyc; q_str.delete(); last_done = -1;
    repeat (20) tick(0, 0, 4, 3);
    cmp("p4n3.strobes", q_str.size(), 3);
    if (q_str.size() == 3) begin
      cmp("p4n3.strobe0", q_str[0] - base, 5);
      cmp("p4n3.strobe1", q_str[1] - base, 9);
      cmp("p4n3.strobe2", q_str[2] - base, 13);
    end
    cmp("p4n3.done", last_done - base, 17);

    // Clamping: P=1 N=0 behaves as P=2 N=1
    tick(1, 0, 1, 0);
    base = cyc; q_str.delete(); last_done = -1;
    repeat (7) tick(0, 0, 1, 0);
    cmp("clamp.strobes", q_str.size(), 1);
    if (q_str.size() == 1) cmp("clamp.strobe0", q_str[0] - base, 2);
    cmp("clamp.done", last_done - base, 4);

    // Abort during the strobe cycle of bit 1
    tick(1, 0, 4, 3);
    base = cyc; q_str.delete(); last_done = -1;
    repeat (9) tick(0, 0, 4, 3);
    tick(0, 1, 4, 3);
    repeat (10) tick(0, 0, 4, 3);
    cmp("abort.strobes", q_str.size(), 1);
    cmp("abort.no_done", last_done, -1);

    // Re-pulsed start and changed bit_period mid-sequence, then a P=8 packet
    tick(1, 0, 4, 3);
    base = cyc; q_str.delete(); last_done = -1;
    repeat (6) tick(0, 0, 4, 3);
    tick(1, 0, 8, 3);
    repeat (11) tick(0, 0, 8, 3);
    cmp("ignore.strobes", q_str.size(), 3);
    if (q_str.size() == 3) cmp("ignore.strobe2", q_str[2] - base, 13);
    cmp("ignore.done", last_done - base, 17);
    tick(1, 0, 8, 3);
    base = cyc; q_str.delete(); last_done = -1;
    repeat (40) tick(0, 0, 8, 3);
    cmp("p8.strobes", q_str.size(), 3);
    if (q_str.size() == 3) cmp("p8.strobe0", q_str[0] - base, 11);
    cmp("p8.done", last_done - base, 35);

    // start and abort together in IDLE
    q_str.delete(); last_done = -1;
    repeat (20) tick(1, 1, 4, 3);
    cmp("start_abort.strobes", q_str.size(), 0);
    cmp("start_abort.busy", busy, 0);

    // Asynchronous reset in the middle of BITS
    tick(1, 0, 4, 3);
    repeat (7) tick(0, 0, 4, 3);
    #2;
    n_rst = 1'b0;
    #1;
    cmp_all_zero("async_reset");
    m_act = 1'b0;
    @(posedge clk);
    #1;
    cmp_all_zero("async_reset_held");
    #2;
    n_rst = 1'b1;
    q_str.delete(); last_done = -1;
    tick(1, 0, 2, 1);
    base = cyc;
    repeat (8) tick(0, 0, 2, 1);
    cmp("post_reset.done", last_done - base, 4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(3) == 0, $urandom_range(29) == 0,
           int'($urandom_range(9)), int'($urandom_range(5)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_timer_ctrl.md
SAMPLE_TIMER_CTRL -- requirements
Module: sample_timer_ctrl

Interface
REQ-001 SHALL have parameter: NUM_CNT_BITS, 8, width of bit-period counter and bit_period port.
REQ-002 SHALL have parameter: NUM_IDX_BITS, 4, width of bit counter, num_bits and bit_index ports.
REQ-003 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port: n_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: start  input  1  request to begin one packet timing sequence.
REQ-006 SHALL have port: abort  input  1  synchronous cancel of the sequence in progress.
REQ-007 SHALL have port: bit_period  input  NUM_CNT_BITS  clock cycles per bit (P).
REQ-008 SHALL have port: num_bits  input  NUM_IDX_BITS  data bits per packet (N).
REQ-009 SHALL have port: busy  output  1  high in every state other than IDLE.
REQ-010 SHALL have port: shift_strobe  output  1  one-cycle pulse at the last cycle of each data bit.
REQ-011 SHALL have port: packet_done  output  1  one-cycle pulse at the last cycle of the stop period.
REQ-012 SHALL have port: bit_index  output  NUM_IDX_BITS  index of the current data bit; 0 outside BITS.

Function
REQ-013 SHALL implement FSM states IDLE, HALF, BITS, STOP; outputs derived from registered state/counters, no input-to-output paths except abort gating (REQ-022).
REQ-014 SHALL, in IDLE with start=1 and abort=0 at an edge (edge 0), capture P and N into internal registers and enter HALF; cycle k = interval following edge k.
REQ-015 SHALL clamp captured values: P<2 -> 2; N=0 -> 1; H = P>>1 using the clamped P.
REQ-016 SHALL hold HALF for exactly H cycles (cycles 0..H-1), then enter BITS with bit_index=0.
REQ-017 SHALL hold each data bit for exactly P cycles; shift_strobe=1 only in the final cycle of each bit; bit_index increments on the edge ending that cycle.
REQ-018 SHALL, after the strobe of bit N-1, enter STOP for exactly P cycles; packet_done=1 only in the final STOP cycle; next state IDLE.
REQ-019 SHALL ignore start while busy=1; a back-to-back start sampled in the first IDLE cycle begins a new sequence normally.
REQ-020 SHALL ignore changes on bit_period/num_bits after capture until the next accepted start.
REQ-021 SHALL, with abort=1 at an edge in any non-IDLE state, return to IDLE and clear both counters and bit_index on that edge.
REQ-022 SHALL force shift_strobe=0 and packet_done=0 during any cycle in which abort=1.
REQ-023 SHALL treat start and abort both high in IDLE as abort: remain IDLE.
REQ-024 SHALL count the cycle counter 1..limit and clear it on each bit/phase rollover; no counter wraps past its captured limit.
REQ-025 SHALL never assert shift_strobe and packet_done in the same cycle.

Reset
REQ-026 SHALL, while n_rst=0, asynchronously force state=IDLE, counters=0, captured P/N=0, busy=0, shift_strobe=0, packet_done=0, bit_index=0.
REQ-027 SHALL abandon any in-progress sequence on reset with no strobe/done emitted, and accept start on the first edge after reset release.

Verification
REQ-028 SHALL be verified by: reset asserted mid-BITS (P=4,N=3) -> all outputs 0 within the same cycle, busy=0 after release until next start.
REQ-029 SHALL be verified by: P=4, N=3, start at edge 0 -> shift_strobe in cycles 5, 9, 13 with bit_index 0,1,2; packet_done in cycle 17; busy high cycles 0..17, low in 18.
REQ-030 SHALL be verified by: P=1, N=0 (clamped to P=2,H=1,N=1) -> shift_strobe in cycle 2, packet_done in cycle 4, busy low in cycle 5.
REQ-031 SHALL be verified by: P=4, N=3, abort=1 in cycle 9 -> no strobe in cycle 9, IDLE and busy=0 from cycle 10, no packet_done.
REQ-032 SHALL be verified by: start re-pulsed in cycle 6 and bit_period changed to 8 mid-sequence -> timing identical to REQ-029; new start in cycle 18 begins a second sequence with P=8.
REQ-033 SHALL be verified by: start=1 and abort=1 together in IDLE -> busy stays 0, no strobes for 20 cycles.
